// File: rtl/tnn_neuron_seq_pkg.sv
// Shared types and constants for the ternary neuron sequencer.
// The clog2 helper lets the top check its accumulator width at elaboration.
package tnn_pkg;

  localparam int WORD_W = 24;
  localparam int PC_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } tnn_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tnn_neuron_seq_if.sv
// Beat input, result output and status signals of one neuron sequencer.
// The master drives beats and consumes results; the slave is the sequencer.
interface tnn_neuron_seq_if #(
  parameter int ACC_W = 8
);
  import tnn_pkg::*;

  logic [ACC_W-1:0]  cfg_thresh;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_x;
  logic [WORD_W-1:0] in_wp;
  logic [WORD_W-1:0] in_wn;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_bit;
  logic              busy;

  modport master (
    output cfg_thresh, in_valid, in_x, in_wp, in_wn, out_ready,
    input  in_ready, out_valid, out_sum, out_bit, busy
  );

  modport slave (
    input  cfg_thresh, in_valid, in_x, in_wp, in_wn, out_ready,
    output in_ready, out_valid, out_sum, out_bit, busy
  );

endinterface

// File: rtl/tnn_neuron_seq_popcount.sv
// Exact 24-bit population count, built as three byte counts summed together.
// Approximate variants with the same ports can be swapped in for exploration.
module popcount24_exact
  import tnn_pkg::*;
(
  input  logic [WORD_W-1:0] i_data,
  output logic [PC_W-1:0]   o_count
);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_byte
      logic [3:0] w_cnt;
      always_comb begin
        w_cnt = '0;
        for (int b = 0; b < 8; b++) begin
          w_cnt = w_cnt + 4'(i_data[gi*8+b]);
        end
      end
    end
  endgenerate

  assign o_count = 5'(g_byte[0].w_cnt) + 5'(g_byte[1].w_cnt) + 5'(g_byte[2].w_cnt);

endmodule

// File: rtl/tnn_neuron_seq.sv
// Ternary neuron sequencer: one shared popcount, time-multiplexed between the
// +1 mask (add) and -1 mask (subtract) of each beat; result on valid/ready.
module tnn_neuron_seq
  import tnn_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int ACC_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  tnn_neuron_seq_if.slave s_if
);

  localparam int BEAT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NWORDS - 1);

  generate
    if (NWORDS < 1) begin : g_nwords_check
      $error("tnn_neuron_seq: NWORDS must be at least 1");
    end
    if (ACC_W < clog2(WORD_W * NWORDS + 1) + 1) begin : g_acc_w_check
      $error("tnn_neuron_seq: ACC_W too narrow for NWORDS beats");
    end
  endgenerate

  tnn_state_t               r_state;
  tnn_state_t               w_state_next;
  logic [BEAT_W-1:0]        r_beat;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_thr;
  logic [WORD_W-1:0]        r_x;
  logic [WORD_W-1:0]        r_wp;
  logic [WORD_W-1:0]        r_wn;
  logic [WORD_W-1:0]        w_pc_in;
  logic [PC_W-1:0]          w_pc;
  logic signed [ACC_W-1:0]  w_pc_ext;

  popcount24_exact u_popcount (
    .i_data  (w_pc_in),
    .o_count (w_pc)
  );

  assign w_pc_ext = {{(ACC_W-PC_W){1'b0}}, w_pc};

  // Popcount input is forced to zero outside POS/NEG so the adder tree stays quiet.
  always_comb begin
    w_state_next = r_state;
    w_pc_in      = '0;
    case (r_state)
      IDLE: begin
        if (s_if.in_valid) begin
          w_state_next = POS;
        end
      end
      POS: begin
        w_pc_in      = r_x & r_wp;
        w_state_next = NEG;
      end
      NEG: begin
        w_pc_in      = r_x & r_wn;
        w_state_next = (r_beat == LAST_BEAT) ? DONE : IDLE;
      end
      DONE: begin
        if (s_if.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_acc  <= '0;
      r_thr  <= '0;
      r_x    <= '0;
      r_wp   <= '0;
      r_wn   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_x  <= s_if.in_x;
            r_wp <= s_if.in_wp;
            r_wn <= s_if.in_wn;
            // Threshold is frozen with the first beat of an evaluation.
            if (r_beat == '0) begin
              r_thr <= s_if.cfg_thresh;
            end
          end
        end
        POS: begin
          r_acc <= r_acc + w_pc_ext;
        end
        NEG: begin
          r_acc <= r_acc - w_pc_ext;
          if (r_beat != LAST_BEAT) begin
            r_beat <= r_beat + BEAT_W'(1);
          end
        end
        DONE: begin
          if (s_if.out_ready) begin
            r_acc  <= '0;
            r_beat <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_if.in_ready  = (r_state == IDLE);
  assign s_if.out_valid = (r_state == DONE);
  assign s_if.out_sum   = (r_state == DONE) ? r_acc : '0;
  assign s_if.out_bit   = (r_state == DONE) && (r_acc >= r_thr);
  assign s_if.busy      = !((r_state == IDLE) && (r_beat == '0));

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// Directed and randomized checks of tnn_neuron_seq against hand-computed sums
// and a bench-side popcount model; one line per completed job.
module tb_tnn_neuron_seq;
  import tnn_pkg::*;

  localparam int NWORDS = 4;
  localparam int ACC_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  tnn_neuron_seq_if #(.ACC_W(ACC_W)) u_if ();

  tnn_neuron_seq #(.NWORDS(NWORDS), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [23:0] x, input logic [23:0] wp,
                           input logic [23:0] wn, input logic [7:0] thr);
    int t;
    t = 0;
    u_if.in_x       = x;
    u_if.in_wp      = wp;
    u_if.in_wn      = wn;
    u_if.cfg_thresh = thr;
    u_if.in_valid   = 1'b1;
    while (!u_if.in_ready && t < 50) begin
      step();
      t++;
    end
    if (!u_if.in_ready) chk("accept_timeout", 32'(u_if.in_ready), 32'(1));
    acc_cyc = cyc;
    step();
    u_if.in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [23:0] x, input logic [23:0] wp,
                          input logic [23:0] wn, input logic [7:0] thr);
    for (int b = 0; b < NWORDS; b++) send_beat(x, wp, wn, thr);
  endtask

  task automatic get_result(input string tag, input logic [7:0] exp_sum,
                            input logic exp_bit, input int hold);
    int t;
    t = 0;
    u_if.out_ready = 1'b0;
    while (!u_if.out_valid && t < 100) begin
      step();
      t++;
    end
    repeat (hold) step();
    u_if.out_ready = 1'b1;
    chk({tag, "_valid"}, 32'(u_if.out_valid), 32'(1));
    chk({tag, "_sum"}, 32'(u_if.out_sum), 32'(exp_sum));
    chk({tag, "_bit"}, 32'(u_if.out_bit), 32'(exp_bit));
    $display("job %s: sum=%0d bit=%0d (expected sum=%0d bit=%0d)", tag,
             $signed(u_if.out_sum), u_if.out_bit, $signed(exp_sum), exp_bit);
    step();
    u_if.out_ready = 1'b0;
    chk({tag, "_cleared"}, 32'(u_if.out_valid), 32'(0));
    chk({tag, "_idle"}, 32'(u_if.busy), 32'(0));
  endtask

  initial begin
    int c0;
    logic [7:0] s_hold;
    logic       b_hold;

    u_if.cfg_thresh = '0;
    u_if.in_valid   = 1'b0;
    u_if.in_x       = '0;
    u_if.in_wp      = '0;
    u_if.in_wn      = '0;
    u_if.out_ready  = 1'b0;
    #2 rst = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(u_if.in_ready), 32'(1));
    chk("rst_out_valid", 32'(u_if.out_valid), 32'(0));
    chk("rst_out_sum", 32'(u_if.out_sum), 32'(0));
    chk("rst_out_bit", 32'(u_if.out_bit), 32'(0));
    chk("rst_busy", 32'(u_if.busy), 32'(0));
    rst = 1'b0;
    step();

    // All-positive weights: 4 x 24 = 96.
    send_job(24'hFFFFFF, 24'hFFFFFF, 24'h000000, 8'd96);
    get_result("t1_thr96", 8'h60, 1'b1, 0);
    send_job(24'hFFFFFF, 24'hFFFFFF, 24'h000000, 8'd97);
    get_result("t1_thr97", 8'h60, 1'b0, 0);

    // All-negative weights: -96.
    send_job(24'hFFFFFF, 24'h000000, 24'hFFFFFF, 8'd0);
    get_result("t2_neg", 8'hA0, 1'b0, 0);

    // Overlapping masks net to zero; 0 >= 0.
    send_job(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 8'd0);
    get_result("t3_overlap", 8'h00, 1'b1, 0);

    // Back-to-back beats: +12 -1 per beat = 44.
    send_beat(24'hFFFFFF, 24'hFFF000, 24'h000001, 8'd44);
    c0 = acc_cyc;
    send_beat(24'hFFFFFF, 24'hFFF000, 24'h000001, 8'd0);
    chk("t4_accept1", 32'(acc_cyc - c0), 32'(3));
    send_beat(24'hFFFFFF, 24'hFFF000, 24'h000001, 8'd0);
    chk("t4_accept2", 32'(acc_cyc - c0), 32'(6));
    send_beat(24'hFFFFFF, 24'hFFF000, 24'h000001, 8'd0);
    chk("t4_accept3", 32'(acc_cyc - c0), 32'(9));
    for (int t = 0; t < 20 && !u_if.out_valid; t++) step();
    chk("t4_latency", 32'(cyc - c0), 32'(12));
    s_hold = u_if.out_sum;
    b_hold = u_if.out_bit;
    chk("t4_sum_first", 32'(s_hold), 32'(8'h2C));
    chk("t4_bit_first", 32'(b_hold), 32'(1));
    u_if.in_x     = 24'hFFFFFF;
    u_if.in_wp    = 24'h000000;
    u_if.in_wn    = 24'hFFFFFF;
    u_if.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_hold_valid", 32'(u_if.out_valid), 32'(1));
      chk("t4_hold_sum", 32'(u_if.out_sum), 32'(8'h2C));
      chk("t4_hold_bit", 32'(u_if.out_bit), 32'(1));
      chk("t4_hold_in_ready", 32'(u_if.in_ready), 32'(0));
    end
    u_if.in_valid = 1'b0;
    get_result("t4_b2b", 8'h2C, 1'b1, 0);

    // Reset during NEG of beat 2 discards the partial sum.
    send_beat(24'hFFFFFF, 24'hFFFFFF, 24'h000000, 8'd0);
    send_beat(24'hFFFFFF, 24'hFFFFFF, 24'h000000, 8'd0);
    send_beat(24'hFFFFFF, 24'hFFFFFF, 24'h000000, 8'd0);
    step();
    chk("t5_busy_before", 32'(u_if.busy), 32'(1));
    chk("t5_in_ready_before", 32'(u_if.in_ready), 32'(0));
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", 32'(u_if.in_ready), 32'(1));
    chk("t5_rst_out_valid", 32'(u_if.out_valid), 32'(0));
    chk("t5_rst_out_sum", 32'(u_if.out_sum), 32'(0));
    chk("t5_rst_out_bit", 32'(u_if.out_bit), 32'(0));
    chk("t5_rst_busy", 32'(u_if.busy), 32'(0));
    step();
    rst = 1'b0;
    step();
    send_job(24'h0000FF, 24'h0000FF, 24'h000000, 8'd32);
    get_result("t5_after_rst", 8'h20, 1'b1, 0);

    // Random gaps, random data, threshold scrambled after beat 0.
    for (int j = 0; j < 1000; j++) begin
      int         exp_sum;
      int         thr_i;
      logic [23:0] x, wp, wn;
      thr_i   = int'($urandom_range(0, 200)) - 100;
      exp_sum = 0;
      for (int b = 0; b < NWORDS; b++) begin
        x  = 24'($urandom);
        wp = 24'($urandom);
        wn = 24'($urandom);
        exp_sum += $countones(x & wp) - $countones(x & wn);
        repeat ($urandom_range(0, 2)) step();
        send_beat(x, wp, wn, (b == 0) ? 8'(thr_i) : 8'($urandom));
      end
      get_result($sformatf("r%0d", j), 8'(exp_sum), (exp_sum >= thr_i),
                 int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
